// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM timer.
// MAX_W bounds the magnitude width any instance may use.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DEAD
    } ch_state_e;

    localparam int MAX_W = 32;
    localparam logic [MAX_W:0] ONE = 1;

    // Absolute value of a sign-extended speed word, clamped to 2^w-1 so the
    // most-negative input still fits in w bits.
    function automatic logic [MAX_W:0] sat_mag(input logic [MAX_W:0] spd, input int unsigned w);
        logic [MAX_W:0] a;
        logic [MAX_W:0] lim;
        a   = spd[MAX_W] ? (~spd + ONE) : spd;
        lim = (ONE << w) - ONE;
        if (a > lim) a = lim;
        return a;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: IDLE/RUN/DEAD state machine, boundary-latched duty and
// direction, reversal deadband counter and the registered duty comparator.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEAD_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH:0]   speed,
    input  logic             bnd,
    input  logic [WIDTH-1:0] cnt_nxt,
    output logic             out,
    output logic             dirp
);

    localparam int DW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;
    localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_PERIODS);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             dir_q, dir_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic             out_q, out_d;

    logic [MAX_W:0]   spd_ext;
    logic [MAX_W:0]   mag_full;
    logic [WIDTH-1:0] mag;
    logic             nz;
    logic             req_fwd;

    always_comb begin
        spd_ext  = {{(MAX_W - WIDTH){speed[WIDTH]}}, speed};
        mag_full = sat_mag(spd_ext, WIDTH);
        mag      = mag_full[WIDTH-1:0];
        nz       = |mag_full;
        req_fwd  = ~speed[WIDTH];
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        if (!en) begin
            state_d = ST_IDLE;
            duty_d  = '0;
        end else if (bnd) begin
            case (state_q)
                // IDLE always carries duty 0, so it follows the RUN rules
                // and never needs a deadband.
                ST_IDLE, ST_RUN: begin
                    state_d = ST_RUN;
                    if (!nz) begin
                        duty_d = '0;
                    end else if (req_fwd != dir_q) begin
                        if (duty_q == '0 || DEAD_PERIODS == 0) begin
                            dir_d  = req_fwd;
                            duty_d = mag;
                        end else begin
                            state_d = ST_DEAD;
                            dead_d  = DEAD_INIT;
                            duty_d  = '0;
                        end
                    end else begin
                        duty_d = mag;
                    end
                end
                ST_DEAD: begin
                    if (nz && req_fwd == dir_q) begin
                        state_d = ST_RUN;
                        duty_d  = mag;
                    end else if (dead_q == DW'(1)) begin
                        state_d = ST_RUN;
                        dir_d   = ~dir_q;
                        duty_d  = mag;
                    end else begin
                        dead_d = dead_q - DW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        out_d = (state_d == ST_RUN) && (cnt_nxt < duty_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b1;
            dead_q  <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign dirp = dir_q;

endmodule

// File: rtl/pwm_multi_timer.sv
// Multi-channel PWM generator: shared prescaler and period counter feeding
// CHANNELS independent pwm_channel instances.
module pwm_multi_timer
    import pwm_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 4,
    parameter int PRESCALE     = 1,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           en,
    input  logic [CHANNELS*(WIDTH+1)-1:0] speed,
    output logic [CHANNELS-1:0]           out,
    output logic [CHANNELS-1:0]           dirp,
    output logic [CHANNELS-1:0]           dirn,
    output logic                          period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             bnd;

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = pre_q + PW'(1);
        cnt_d = cnt_q;
        if (tick) begin
            pre_d = '0;
            cnt_d = cnt_q + WIDTH'(1);
        end
        bnd = tick && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    // Decoded straight from the counter flops; gated so it stays low in reset.
    assign period_start = ~rst & (cnt_q == '0) & (pre_q == '0);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .WIDTH        (WIDTH),
            .DEAD_PERIODS (DEAD_PERIODS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .speed   (speed[g*(WIDTH+1) +: WIDTH+1]),
            .bnd     (bnd),
            .cnt_nxt (cnt_d),
            .out     (out[g]),
            .dirp    (dirp[g])
        );
    end

    assign dirn = ~dirp;

endmodule

// File: tb/tb_pwm_multi_timer.sv
// Randomized bench for pwm_multi_timer: two configurations checked every
// cycle against a tick-count based model, plus directed literal pins.
module tb_pwm_multi_timer;

    localparam int W1 = 8, C1 = 4, P1 = 1, D1 = 2;
    localparam int W2 = 4, C2 = 2, P2 = 3, D2 = 0;
    localparam int CW [2] = '{W1, W2};
    localparam int CC [2] = '{C1, C2};
    localparam int CP [2] = '{P1, P2};
    localparam int CD [2] = '{D1, D2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst1 = 1'b0, rst2 = 1'b0;
    logic [C1-1:0]           en1 = '0;
    logic [C1*(W1+1)-1:0]    speed1 = '0;
    logic [C1-1:0]           out1, dirp1, dirn1;
    logic                    ps1;
    logic [C2-1:0]           en2 = '0;
    logic [C2*(W2+1)-1:0]    speed2 = '0;
    logic [C2-1:0]           out2, dirp2, dirn2;
    logic                    ps2;

    pwm_multi_timer #(.WIDTH(W1), .CHANNELS(C1), .PRESCALE(P1), .DEAD_PERIODS(D1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .speed(speed1),
        .out(out1), .dirp(dirp1), .dirn(dirn1), .period_start(ps1));

    pwm_multi_timer #(.WIDTH(W2), .CHANNELS(C2), .PRESCALE(P2), .DEAD_PERIODS(D2)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .speed(speed2),
        .out(out2), .dirp(dirp2), .dirn(dirn2), .period_start(ps2));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Model: time is a tick count since reset release; the counter, boundary
    // and period_start follow from it arithmetically. Modes 0/1/2 = IDLE/RUN/DEAD.
    int m_t [2];
    int m_mode [2][4];
    int m_duty [2][4];
    int m_dir  [2][4];
    int m_dead [2][4];

    task automatic model_reset(input int d);
        m_t[d] = 0;
        for (int c = 0; c < 4; c++) begin
            m_mode[d][c] = 0; m_duty[d][c] = 0; m_dir[d][c] = 1; m_dead[d][c] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] e, input int spd [4]);
        int plen, mx, mg, fwd;
        bit bnd;
        plen = CP[d] << CW[d];
        bnd  = (m_t[d] % plen) == plen - 1;
        mx   = (1 << CW[d]) - 1;
        for (int c = 0; c < CC[d]; c++) begin
            mg  = (spd[c] < 0) ? -spd[c] : spd[c];
            if (mg > mx) mg = mx;
            fwd = (spd[c] >= 0) ? 1 : 0;
            if (!e[c]) begin
                m_mode[d][c] = 0; m_duty[d][c] = 0;
            end else if (bnd) begin
                if (m_mode[d][c] == 2) begin
                    if (mg != 0 && fwd == m_dir[d][c]) begin
                        m_mode[d][c] = 1; m_duty[d][c] = mg;
                    end else if (m_dead[d][c] == 1) begin
                        m_mode[d][c] = 1; m_duty[d][c] = mg; m_dir[d][c] = 1 - m_dir[d][c];
                    end else begin
                        m_dead[d][c] = m_dead[d][c] - 1;
                    end
                end else begin
                    m_mode[d][c] = 1;
                    if (mg == 0) m_duty[d][c] = 0;
                    else if (fwd == m_dir[d][c]) m_duty[d][c] = mg;
                    else if (m_duty[d][c] == 0 || CD[d] == 0) begin
                        m_dir[d][c] = fwd; m_duty[d][c] = mg;
                    end else begin
                        m_mode[d][c] = 2; m_dead[d][c] = CD[d]; m_duty[d][c] = 0;
                    end
                end
            end
        end
        m_t[d] = m_t[d] + 1;
    endtask

    task automatic cyc(input int d, input bit r, input logic [3:0] o, input logic [3:0] dp,
                       input logic [3:0] dn, input logic ps, input logic [3:0] e, input int spd [4]);
        int mask, eo, edp, cnt;
        mask = (1 << CC[d]) - 1;
        if (r) begin
            model_reset(d);
            chk($sformatf("reset_outs%0d", d), {o, dp, dn, ps}, {4'(0), 4'(mask), 4'(0), 1'b0});
        end else begin
            eo = 0; edp = 0;
            cnt = (m_t[d] / CP[d]) % (1 << CW[d]);
            for (int c = 0; c < CC[d]; c++) begin
                if (m_mode[d][c] == 1 && cnt < m_duty[d][c]) eo |= (1 << c);
                if (m_dir[d][c] == 1) edp |= (1 << c);
            end
            chk($sformatf("out%0d t=%0d", d, m_t[d]), o, eo);
            chk($sformatf("dirp%0d t=%0d", d, m_t[d]), dp, edp);
            chk($sformatf("dirn%0d t=%0d", d, m_t[d]), dn, ~edp & mask);
            chk($sformatf("period_start%0d t=%0d", d, m_t[d]), ps, (m_t[d] % (CP[d] << CW[d])) == 0);
            model_step(d, e, spd);
        end
    endtask

    int s1 [4];
    int s2 [4];
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            s1[c] = (c < C1) ? int'($signed(speed1[c*(W1+1) +: W1+1])) : 0;
            s2[c] = (c < C2) ? int'($signed(speed2[c*(W2+1) +: W2+1])) : 0;
        end
        cyc(0, rst1, out1, dirp1, dirn1, ps1, en1, s1);
        cyc(1, rst2, {2'b0, out2}, {2'b0, dirp2}, {2'b0, dirn2}, ps2, {2'b0, en2}, s2);
    end

    // Per-period high-time history of dut1 channel 0, plus period_start spacing.
    int npd = 0, last_hi = 0, acc = 0, gap = 0;
    bit seen_ps = 0;
    always @(negedge clk) begin
        if (rst1) begin
            acc = 0; gap = 0; seen_ps = 0;
        end else if (ps1) begin
            if (seen_ps) chk("ps_gap", gap, 256);
            seen_ps = 1; gap = 1; last_hi = acc; acc = int'(out1[0]); npd++;
        end else begin
            gap++; acc += int'(out1[0]);
        end
    end

    task automatic next_period(output int hi);
        int n0;
        bit ok;
        n0 = npd; ok = 0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(posedge clk);
            if (npd != n0) ok = 1;
        end
        #1;
        if (!ok) begin
            errors++; checks++;
            $display("FAIL next_period: got timeout want period_start");
        end
        hi = last_hi;
    endtask

    task automatic set1(input int c, input int v);
        speed1[c*(W1+1) +: W1+1] = (W1+1)'(v);
    endtask

    task automatic set2(input int c, input int v);
        speed2[c*(W2+1) +: W2+1] = (W2+1)'(v);
    endtask

    task automatic expect_periods(input string name, input int e0, input int e1, input int e2, input int e3);
        int hi;
        int ev [4];
        ev = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            next_period(hi);
            chk($sformatf("%s[%0d]", name, k), hi, ev[k]);
        end
    endtask

    initial begin
        int hi;
        bit found;
        #1; rst1 = 1'b1; rst2 = 1'b1;
        #1;
        chk("reset_out1", out1, 0);
        chk("reset_dirp1", dirp1, 4'hF);
        chk("reset_ps1", ps1, 0);
        repeat (2) @(posedge clk);
        #1;
        en1 = '1; en2 = '1;
        set1(0, 64); set1(1, -1); set1(2, -256); set1(3, 37);
        set2(0, 5); set2(1, -16);
        rst1 = 1'b0; rst2 = 1'b0;

        next_period(hi);
        next_period(hi); chk("idle_first_period", hi, 0);
        next_period(hi); chk("basic_duty64", hi, 64);
        chk("basic_dirp", dirp1[0], 1);

        set1(0, -256);
        expect_periods("sat_rev", 64, 0, 0, 255);
        chk("sat_dirn", dirn1[0], 1);
        set1(0, 100);
        expect_periods("rev_fwd", 255, 0, 0, 100);
        chk("rev_fwd_dirp", dirp1[0], 1);
        set1(0, -100);
        expect_periods("rev_neg", 100, 0, 0, 100);
        chk("rev_neg_dirn", dirn1[0], 1);
        set1(0, 10);
        expect_periods("rev_small", 100, 0, 0, 10);

        repeat (49) @(posedge clk);
        #1;
        set1(0, 200);
        next_period(hi); chk("mid_keep10", hi, 10);
        next_period(hi); chk("mid_next200", hi, 200);

        set1(0, 100);
        next_period(hi);
        next_period(hi); chk("pre_drop100", hi, 100);
        repeat (4) @(posedge clk);
        #1;
        en1[0] = 1'b0;
        @(negedge clk); chk("drop_cnt5_high", out1[0], 1);
        @(negedge clk); chk("drop_cnt6_low", out1[0], 0);
        @(posedge clk); #1;
        en1[0] = 1'b1;
        next_period(hi); chk("drop_period", hi, 6);
        next_period(hi); chk("reenable_period", hi, 100);

        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < C1; c++) begin
                en1[c] = ($urandom_range(0, 7) != 0);
                set1(c, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 511)));
            end
            for (int c = 0; c < C2; c++) begin
                en2[c] = ($urandom_range(0, 7) != 0);
                set2(c, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 31)));
            end
            repeat ($urandom_range(1, 700)) @(posedge clk);
            #1;
        end

        en2 = '1; set2(0, 2);
        repeat (150) @(posedge clk);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk); #1;
            if (((m_t[1] / P2) % (1 << W2)) == 1) found = 1;
        end
        chk("find_cnt1", found, 1);
        @(posedge clk); #2;
        chk("pre_rst_out2", out2[0], 1);
        rst2 = 1'b1;
        #1;
        chk("async_rst_out2", out2, 0);
        chk("async_rst_dirp2", dirp2, 2'b11);
        chk("async_rst_dirn2", dirn2, 0);
        chk("async_rst_ps2", ps2, 0);
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b0;
        repeat (48) @(negedge clk);
        hi = 0;
        repeat (48) begin
            @(negedge clk);
            hi += int'(out2[0]);
        end
        chk("prescale_high", hi, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
